// File: rtl/clk_mon_pkg.sv
// Shared types and width helpers for the divided-clock monitor.
package clk_mon_pkg;

  typedef enum logic [1:0] {IDLE, SYNC, MEAS, LOCK} state_e;

  localparam int unsigned MATCH_W = 4;

  function automatic int unsigned cw_of(input int unsigned max_period);
    return $clog2(max_period + 1);
  endfunction

endpackage

// File: rtl/clk_div_monitor_if.sv
// Stimulus/result bundle between a divided-clock source and its monitor.
interface clk_div_monitor_if #(
  parameter int unsigned CW = 5
);
  logic          EN;
  logic          DIV_I;
  logic [CW-1:0] PERIOD_O;
  logic [CW-1:0] HIGH_O;
  logic          VALID_O;
  logic          LOCKED_O;
  logic          ERR_O;
  logic          TIMEOUT_O;

  modport master (
    output EN, DIV_I,
    input  PERIOD_O, HIGH_O, VALID_O, LOCKED_O, ERR_O, TIMEOUT_O
  );

  modport slave (
    input  EN, DIV_I,
    output PERIOD_O, HIGH_O, VALID_O, LOCKED_O, ERR_O, TIMEOUT_O
  );
endinterface

// File: rtl/clk_mon_period_cnt.sv
// Rising-edge detect on the divided clock plus saturating period and high-time counters.
module clk_mon_period_cnt import clk_mon_pkg::*; #(
  parameter int unsigned MAX_PERIOD = 16,
  parameter int unsigned CW         = cw_of(MAX_PERIOD)
) (
  input  logic          clk_i,
  input  logic          rstn_i,
  input  logic          en_i,
  input  logic          div_i,
  output logic          rise_c_o,
  output logic [CW-1:0] cnt_o,
  output logic [CW-1:0] hcnt_o,
  output logic          sat_c_o
);

  logic          prev_q, prev_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] hcnt_q, hcnt_d;

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      prev_q <= 1'b0;
      cnt_q  <= '0;
      hcnt_q <= '0;
    end else begin
      prev_q <= prev_d;
      cnt_q  <= cnt_d;
      hcnt_q <= hcnt_d;
    end
  end

  assign rise_c_o = div_i & ~prev_q;
  assign sat_c_o  = (cnt_q == CW'(MAX_PERIOD));

  // Disabled monitor drops any partial measurement.
  always_comb begin
    prev_d = div_i;
    cnt_d  = cnt_q;
    hcnt_d = hcnt_q;
    if (!en_i) begin
      cnt_d  = '0;
      hcnt_d = '0;
    end else if (rise_c_o) begin
      cnt_d  = CW'(1);
      hcnt_d = CW'(1);
    end else begin
      if (!sat_c_o) cnt_d = cnt_q + CW'(1);
      if (div_i && (hcnt_q != CW'(MAX_PERIOD))) hcnt_d = hcnt_q + CW'(1);
    end
  end

  assign cnt_o  = cnt_q;
  assign hcnt_o = hcnt_q;

endmodule

// File: rtl/clk_div_monitor.sv
// Measures period/high time of a divided clock, tracks ratio stability and flags errors.
module clk_div_monitor import clk_mon_pkg::*; #(
  parameter int unsigned MAX_PERIOD = 16,
  parameter int unsigned LOCK_COUNT = 4,
  parameter int unsigned EXPECT_DIV = 0
) (
  input logic              CLK,
  input logic              RSTN,
  clk_div_monitor_if.slave mon
);

  localparam int unsigned CW = cw_of(MAX_PERIOD);

  logic          rise_c, sat_c, same_c, exp_ok_c;
  logic [CW-1:0] cnt, hcnt;

  state_e             state_q, state_d;
  logic [CW-1:0]      period_q, period_d, high_q, high_d;
  logic [MATCH_W-1:0] match_q, match_d, match_inc_c;
  logic               valid_q, valid_d, locked_q, locked_d;
  logic               err_q, err_d, timeout_q, timeout_d;

  clk_mon_period_cnt #(.MAX_PERIOD(MAX_PERIOD), .CW(CW)) u_cnt (
    .clk_i    (CLK),
    .rstn_i   (RSTN),
    .en_i     (mon.EN),
    .div_i    (mon.DIV_I),
    .rise_c_o (rise_c),
    .cnt_o    (cnt),
    .hcnt_o   (hcnt),
    .sat_c_o  (sat_c)
  );

  // The last reported capture doubles as the stability reference.
  assign same_c      = (cnt == period_q) && (hcnt == high_q);
  assign exp_ok_c    = (EXPECT_DIV == 0) || (cnt == CW'(EXPECT_DIV));
  assign match_inc_c = (match_q == MATCH_W'(LOCK_COUNT)) ? match_q : match_q + MATCH_W'(1);

  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      state_q   <= IDLE;
      period_q  <= '0;
      high_q    <= '0;
      match_q   <= '0;
      valid_q   <= 1'b0;
      locked_q  <= 1'b0;
      err_q     <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      period_q  <= period_d;
      high_q    <= high_d;
      match_q   <= match_d;
      valid_q   <= valid_d;
      locked_q  <= locked_d;
      err_q     <= err_d;
      timeout_q <= timeout_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    period_d  = period_q;
    high_d    = high_q;
    match_d   = match_q;
    locked_d  = locked_q;
    valid_d   = 1'b0;
    err_d     = 1'b0;
    timeout_d = 1'b0;
    if (!mon.EN) begin
      state_d  = IDLE;
      period_d = '0;
      high_d   = '0;
      match_d  = '0;
      locked_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: state_d = SYNC;
        SYNC: if (rise_c) state_d = MEAS;
        MEAS, LOCK: begin
          if (rise_c) begin
            valid_d  = 1'b1;
            period_d = cnt;
            high_d   = hcnt;
            if (!exp_ok_c) begin
              err_d    = 1'b1;
              match_d  = '0;
              locked_d = 1'b0;
              state_d  = MEAS;
            end else if ((state_q == LOCK) && !same_c) begin
              err_d    = 1'b1;
              match_d  = MATCH_W'(1);
              locked_d = 1'b0;
              state_d  = MEAS;
            end else begin
              match_d = same_c ? match_inc_c : MATCH_W'(1);
              if (match_d == MATCH_W'(LOCK_COUNT)) begin
                locked_d = 1'b1;
                state_d  = LOCK;
              end
            end
          end else if (sat_c) begin
            // A rise on the saturating cycle is a capture, so only a silent one times out.
            timeout_d = 1'b1;
            err_d     = (state_q == LOCK);
            match_d   = '0;
            locked_d  = 1'b0;
            state_d   = SYNC;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign mon.PERIOD_O  = period_q;
  assign mon.HIGH_O    = high_q;
  assign mon.VALID_O   = valid_q;
  assign mon.LOCKED_O  = locked_q;
  assign mon.ERR_O     = err_q;
  assign mon.TIMEOUT_O = timeout_q;

endmodule

// File: tb/tb_clk_div_monitor.sv
// Bench for clk_div_monitor: three configurations checked against an edge-timing model plus directed scenarios.
module tb_clk_div_monitor;
  import clk_mon_pkg::*;

  typedef struct {
    int period;
    int high;
    int valid;
    int locked;
    int err;
    int to;
  } obs_t;

  localparam int P_MAX [3] = '{16, 16, 8};
  localparam int P_LC  [3] = '{4, 4, 4};
  localparam int P_EXP [3] = '{0, 6, 0};

  bit clk = 1'b0;
  always #5 clk = ~clk;

  int nvec = 0;
  int nerr = 0;
  int cyc  = 0;
  bit cmp_on = 1'b0;

  logic rstn_v [3];
  logic en_v   [3];
  logic div_v  [3];
  int   dn [3]      = '{0, 0, 0};
  int   dhi [3]     = '{0, 0, 0};
  int   ph [3]      = '{0, 0, 0};
  int   dn_next [3] = '{0, 0, 0};
  int   dhi_next [3] = '{0, 0, 0};

  clk_div_monitor_if #(.CW(cw_of(16))) if_a ();
  clk_div_monitor_if #(.CW(cw_of(16))) if_e ();
  clk_div_monitor_if #(.CW(cw_of(8)))  if_b ();

  assign if_a.EN = en_v[0];  assign if_a.DIV_I = div_v[0];
  assign if_e.EN = en_v[1];  assign if_e.DIV_I = div_v[1];
  assign if_b.EN = en_v[2];  assign if_b.DIV_I = div_v[2];

  clk_div_monitor #(.MAX_PERIOD(16), .LOCK_COUNT(4), .EXPECT_DIV(0)) u_a (
    .CLK(clk), .RSTN(rstn_v[0]), .mon(if_a));
  clk_div_monitor #(.MAX_PERIOD(16), .LOCK_COUNT(4), .EXPECT_DIV(6)) u_e (
    .CLK(clk), .RSTN(rstn_v[1]), .mon(if_e));
  clk_div_monitor #(.MAX_PERIOD(8), .LOCK_COUNT(4), .EXPECT_DIV(0)) u_b (
    .CLK(clk), .RSTN(rstn_v[2]), .mon(if_b));

  function automatic obs_t get_obs(input int d);
    obs_t o;
    o = '{0, 0, 0, 0, 0, 0};
    case (d)
      0: o = '{int'(if_a.PERIOD_O), int'(if_a.HIGH_O), int'(if_a.VALID_O),
               int'(if_a.LOCKED_O), int'(if_a.ERR_O), int'(if_a.TIMEOUT_O)};
      1: o = '{int'(if_e.PERIOD_O), int'(if_e.HIGH_O), int'(if_e.VALID_O),
               int'(if_e.LOCKED_O), int'(if_e.ERR_O), int'(if_e.TIMEOUT_O)};
      2: o = '{int'(if_b.PERIOD_O), int'(if_b.HIGH_O), int'(if_b.VALID_O),
               int'(if_b.LOCKED_O), int'(if_b.ERR_O), int'(if_b.TIMEOUT_O)};
      default: ;
    endcase
    return o;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    nvec++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Divided-clock sources: ratio changes take effect at the next period boundary.
  always @(negedge clk) begin
    for (int d = 0; d < 3; d++) begin
      if (dn[d] == 0) begin
        if (dn_next[d] != 0) begin
          dn[d] = dn_next[d]; dhi[d] = dhi_next[d]; ph[d] = 0;
        end
      end else begin
        ph[d] = ph[d] + 1;
        if (ph[d] >= dn[d]) begin
          ph[d] = 0; dn[d] = dn_next[d]; dhi[d] = dhi_next[d];
        end
      end
      div_v[d] = (dn[d] != 0) && (ph[d] < dhi[d]);
    end
  end

  // Model: time since the last rising edge and high samples within it.
  obs_t e [3];
  int m_mode [3]   = '{0, 0, 0};   // 0 off, 1 hunting first edge, 2 tracking
  int m_prev [3]   = '{0, 0, 0};
  int m_since [3]  = '{0, 0, 0};
  int m_hi [3]     = '{0, 0, 0};
  int m_streak [3] = '{0, 0, 0};
  int m_lastp [3]  = '{0, 0, 0};
  int m_lasth [3]  = '{0, 0, 0};

  task automatic model_step(input int d);
    int rise, p, h, same;
    e[d].valid = 0; e[d].err = 0; e[d].to = 0;
    if (!rstn_v[d]) begin
      m_mode[d] = 0; m_prev[d] = 0; m_streak[d] = 0;
      e[d].period = 0; e[d].high = 0; e[d].locked = 0;
      return;
    end
    rise = (div_v[d] && m_prev[d] == 0) ? 1 : 0;
    m_prev[d] = int'(div_v[d]);
    if (!en_v[d]) begin
      m_mode[d] = 0; m_streak[d] = 0;
      e[d].period = 0; e[d].high = 0; e[d].locked = 0;
    end else if (m_mode[d] == 0) begin
      m_mode[d] = 1;
    end else if (m_mode[d] == 1) begin
      if (rise != 0) begin m_mode[d] = 2; m_since[d] = 0; m_hi[d] = 1; end
    end else begin
      m_since[d] = m_since[d] + 1;
      if (rise != 0) begin
        p = m_since[d];
        h = (m_hi[d] > P_MAX[d]) ? P_MAX[d] : m_hi[d];
        same = (p == m_lastp[d] && h == m_lasth[d]) ? 1 : 0;
        e[d].valid = 1; e[d].period = p; e[d].high = h;
        if (P_EXP[d] != 0 && p != P_EXP[d]) begin
          e[d].err = 1; e[d].locked = 0; m_streak[d] = 0;
        end else if (e[d].locked != 0 && same == 0) begin
          e[d].err = 1; e[d].locked = 0; m_streak[d] = 1;
        end else begin
          m_streak[d] = (same != 0) ? m_streak[d] + 1 : 1;
          if (m_streak[d] > P_LC[d]) m_streak[d] = P_LC[d];
          if (m_streak[d] == P_LC[d]) e[d].locked = 1;
        end
        m_lastp[d] = p; m_lasth[d] = h;
        m_since[d] = 0; m_hi[d] = 1;
      end else if (m_since[d] == P_MAX[d]) begin
        e[d].to = 1; e[d].err = e[d].locked; e[d].locked = 0;
        m_streak[d] = 0; m_mode[d] = 1;
      end else begin
        m_hi[d] = m_hi[d] + int'(div_v[d]);
      end
    end
  endtask

  always @(posedge clk) begin
    cyc = cyc + 1;
    for (int d = 0; d < 3; d++) model_step(d);
  end

  always @(negedge clk) begin
    obs_t o;
    if (cmp_on) begin
      for (int d = 0; d < 3; d++) begin
        o = get_obs(d);
        chk($sformatf("d%0d PERIOD_O", d),  o.period, e[d].period);
        chk($sformatf("d%0d HIGH_O", d),    o.high,   e[d].high);
        chk($sformatf("d%0d VALID_O", d),   o.valid,  e[d].valid);
        chk($sformatf("d%0d LOCKED_O", d),  o.locked, e[d].locked);
        chk($sformatf("d%0d ERR_O", d),     o.err,    e[d].err);
        chk($sformatf("d%0d TIMEOUT_O", d), o.to,     e[d].to);
      end
    end
  end

  task automatic wait_valid(input int d, input int budget, output int at, output obs_t o, inout int tos);
    at = -1;
    o = '{0, 0, 0, 0, 0, 0};
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      o = get_obs(d);
      if (o.to != 0) tos++;
      if (o.valid != 0) begin at = cyc; return; end
    end
    chk($sformatf("d%0d valid wait", d), 0, 1);
  endtask

  task automatic relock_check(input string tag, input int d, input int n);
    int at, c0, tos;
    obs_t o;
    tos = 0;
    wait_valid(d, 40, c0, o, tos);
    chk({tag, " first period"}, o.period, n);
    chk({tag, " first unlocked"}, o.locked, 0);
    repeat (2) begin
      wait_valid(d, 40, at, o, tos);
      chk({tag, " mid unlocked"}, o.locked, 0);
    end
    wait_valid(d, 40, at, o, tos);
    chk({tag, " locked"}, o.locked, 1);
    chk({tag, " lock latency"}, at - c0, 3 * n);
  endtask

  initial begin
    int at, c0, last, tos, nv;
    bit seen;
    obs_t o;
    rstn_v = '{1'b0, 1'b0, 1'b0};
    en_v   = '{1'b1, 1'b1, 1'b0};
    div_v  = '{1'b0, 1'b0, 1'b0};
    dn_next  = '{4, 5, 8};
    dhi_next = '{2, 2, 4};
    @(posedge clk);
    cmp_on = 1'b1;
    @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      o = get_obs(d);
      chk($sformatf("d%0d reset PERIOD", d), o.period, 0);
      chk($sformatf("d%0d reset LOCKED", d), o.locked, 0);
      chk($sformatf("d%0d reset VALID", d), o.valid, 0);
    end
    repeat (2) @(negedge clk);
    rstn_v = '{1'b1, 1'b1, 1'b1};

    // Divide 4, 50% duty.
    relock_check("div4", 0, 4);
    tos = 0;
    wait_valid(0, 40, at, o, tos);
    chk("div4 high", o.high, 2);
    chk("div4 no err", o.err, 0);

    // Ratio change 4 -> 3 while locked.
    dn_next[0] = 3; dhi_next[0] = 1;
    for (int i = 0; i < 3; i++) begin
      wait_valid(0, 40, c0, o, tos);
      if (o.period == 3) break;
    end
    chk("sw3 period", o.period, 3);
    chk("sw3 high", o.high, 1);
    chk("sw3 err", o.err, 1);
    chk("sw3 unlocked", o.locked, 0);
    repeat (2) wait_valid(0, 40, at, o, tos);
    wait_valid(0, 40, at, o, tos);
    chk("sw3 relock", o.locked, 1);
    chk("sw3 relock latency", at - c0, 9);

    // Divide 2, then stop the clock while locked.
    dn_next[0] = 2; dhi_next[0] = 1;
    last = -1;
    for (int i = 0; i < 8; i++) begin
      wait_valid(0, 40, last, o, tos);
      if (o.locked != 0 && o.period == 2) break;
    end
    chk("div2 locked", o.locked, 1);
    dn_next[0] = 0;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      o = get_obs(0);
      if (o.valid != 0) last = cyc;
      if (o.to != 0) begin seen = 1'b1; at = cyc; end
    end
    chk("stop timeout seen", int'(seen), 1);
    chk("stop err", o.err, 1);
    chk("stop unlocked", o.locked, 0);
    chk("stop timeout delay", at - last, 16);
    dn_next[0] = 2;
    relock_check("restart", 0, 2);

    // One-cycle reset while locked.
    rstn_v[0] = 1'b0;
    @(negedge clk);
    o = get_obs(0);
    chk("rst period", o.period, 0);
    chk("rst high", o.high, 0);
    chk("rst locked", o.locked, 0);
    chk("rst valid", o.valid, 0);
    rstn_v[0] = 1'b1;
    relock_check("after rst", 0, 2);

    // One-cycle enable drop while locked.
    en_v[0] = 1'b0;
    @(negedge clk);
    o = get_obs(0);
    chk("en0 period", o.period, 0);
    chk("en0 locked", o.locked, 0);
    chk("en0 flags", o.valid + o.err + o.to, 0);
    en_v[0] = 1'b1;
    relock_check("after en0", 0, 2);

    // Expected divide 6, actual 5.
    for (int i = 0; i < 3; i++) begin
      wait_valid(1, 40, at, o, tos);
      chk("exp6 period", o.period, 5);
      chk("exp6 high", o.high, 2);
      chk("exp6 err", o.err, 1);
      chk("exp6 unlocked", o.locked, 0);
    end

    // MAX_PERIOD 8: divide 8 locks, divide 9 times out.
    en_v[2] = 1'b1;
    tos = 0;
    relock_check("max8", 2, 8);
    chk("max8 no timeout", tos, 0);
    dn_next[2] = 9; dhi_next[2] = 4;
    last = at;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      o = get_obs(2);
      if (o.valid != 0) last = cyc;
      if (o.to != 0) begin seen = 1'b1; at = cyc; end
    end
    chk("div9 timeout seen", int'(seen), 1);
    chk("div9 err", o.err, 1);
    chk("div9 unlocked", o.locked, 0);
    chk("div9 timeout delay", at - last, 8);
    nv = 0; tos = 0;
    repeat (36) begin
      @(negedge clk);
      o = get_obs(2);
      nv += o.valid;
      tos += o.to;
    end
    chk("div9 no valid", nv, 0);
    chk("div9 timeouts", tos, 4);

    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
